// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg
//   Shared types for the instruction-ROM arbiter.
//   NADDR_BITS_DEF : default byte-address width (ROM depth = 1 << (NADDR_BITS-2) words)
//   port_e         : requester identity, used by the round-robin pointer
//   resp_t         : one parked ROM response (valid, alignment error, data word)
package imem_arb_pkg;

  localparam int NADDR_BITS_DEF = 8;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  function automatic logic misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/imem_resp_slot.sv
// imem_resp_slot
//   Response slot for one requester. Tracks the read issued last cycle and parks
//   the ROM word in a hold register when the requester is not ready for it.
// Ports
//   clock, reset  : system clock, async active-high reset
//   gnt           : this port was granted a ROM read this cycle
//   err_in        : the granted address was misaligned
//   mem_q         : registered ROM data (valid the cycle after the grant)
//   rready        : requester accepts the response
//   free          : slot can take a new grant this cycle
//   rvalid/rdata/err : response towards the requester
module imem_resp_slot
  import imem_arb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        gnt,
  input  logic        err_in,
  input  logic [31:0] mem_q,
  input  logic        rready,
  output logic        free,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  logic  in_flight;
  logic  flight_err;
  resp_t hold;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_flight  <= 1'b0;
      flight_err <= 1'b0;
      hold       <= '0;
    end else begin
      in_flight <= gnt;
      if (gnt) flight_err <= err_in;
      // in_flight and hold.valid are never both set: a grant needs a free slot
      if (in_flight && !rready) begin
        hold.valid <= 1'b1;
        hold.err   <= flight_err;
        hold.data  <= mem_q;
      end else if (hold.valid && rready) begin
        hold.valid <= 1'b0;
      end
    end
  end

  assign rvalid = in_flight | hold.valid;
  assign rdata  = in_flight ? mem_q : (hold.valid ? hold.data : 32'd0);
  assign err    = in_flight ? flight_err : (hold.valid & hold.err);
  // A response leaving this cycle frees the slot, which allows back-to-back reads
  assign free   = !rvalid || rready;

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares a single-port synchronous-read instruction ROM between the fetch
//   port (F) and the load port (D). One grant per cycle; the granted address
//   drives the ROM and the registered ROM word returns to the owner next cycle.
//   Build option IMEM_ARB_RR_EN: round-robin priority between the ports;
//   otherwise D always beats F.
// Ports
//   clock, reset                         : system clock, async active-high reset
//   f_req/f_addr/f_gnt                   : fetch request, byte address, grant
//   f_rvalid/f_rdata/f_rready/f_err      : fetch response channel
//   d_*                                  : same set for the load port
//   mem_address                          : ROM address (granted addr, else 0)
//   mem_q                                : ROM data, one cycle after address
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int NADDR_BITS = NADDR_BITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [NADDR_BITS-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [31:0]           f_rdata,
  input  logic                  f_rready,
  output logic                  f_err,
  input  logic                  d_req,
  input  logic [NADDR_BITS-1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  input  logic                  d_rready,
  output logic                  d_err,
  output logic [NADDR_BITS-1:0] mem_address,
  input  logic [31:0]           mem_q
);

  logic f_free, d_free;
  logic f_elig, d_elig;
  logic d_wins;

  // Grants are held off while reset is asserted so all outputs read 0
  assign f_elig = !reset && f_req && f_free;
  assign d_elig = !reset && d_req && d_free;

`ifdef IMEM_ARB_RR_EN
  port_e last_grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      last_grant <= PORT_F;
    else if (f_gnt) last_grant <= PORT_F;
    else if (d_gnt) last_grant <= PORT_D;
  end

  assign d_wins = d_elig && (!f_elig || last_grant == PORT_F);
`else
  assign d_wins = d_elig;
`endif

  assign d_gnt = d_wins;
  assign f_gnt = f_elig && !d_wins;

  // The ROM ignores addr[1:0]; misalignment is reported, not corrected
  always_comb begin
    mem_address = '0;
    if (d_gnt)      mem_address = d_addr;
    else if (f_gnt) mem_address = f_addr;
  end

  imem_resp_slot u_slot_f (
    .clock  (clock),
    .reset  (reset),
    .gnt    (f_gnt),
    .err_in (misaligned(f_addr[1:0])),
    .mem_q  (mem_q),
    .rready (f_rready),
    .free   (f_free),
    .rvalid (f_rvalid),
    .rdata  (f_rdata),
    .err    (f_err)
  );

  imem_resp_slot u_slot_d (
    .clock  (clock),
    .reset  (reset),
    .gnt    (d_gnt),
    .err_in (misaligned(d_addr[1:0])),
    .mem_q  (mem_q),
    .rready (d_rready),
    .free   (d_free),
    .rvalid (d_rvalid),
    .rdata  (d_rdata),
    .err    (d_err)
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter
//   Scoreboard bench: a reference model predicts grants and pushes the expected
//   ROM word per port; a monitor pops and compares whenever a response is due.
module tb_imem_arbiter;

  localparam int AW = 8;
`ifdef IMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          f_req = 1'b0, d_req = 1'b0;
  logic [AW-1:0] f_addr = '0, d_addr = '0;
  logic          f_rready = 1'b1, d_rready = 1'b1;
  logic          f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err;
  logic [31:0]   f_rdata, d_rdata;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_q = 32'd0;

  imem_arbiter #(.NADDR_BITS(AW)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_rready(f_rready), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_rready(d_rready), .d_err(d_err),
    .mem_address(mem_address), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // ROM model: mem[i] = A000_0000 + i
  always @(posedge clock) mem_q <= 32'hA000_0000 + 32'(mem_address >> 2);

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t fq[$];
  exp_t dq[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   last_f = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t rom_read(input logic [AW-1:0] a);
    exp_t e;
    e.err  = (a % 4) != 0;
    e.data = 32'hA000_0000 + 32'(a / 4);
    return e;
  endfunction

  // Monitor: compares responses against the scoreboard queues
  always @(negedge clock) begin
    if (reset) begin
      chk("rst_f_gnt", {31'd0, f_gnt}, 0);
      chk("rst_d_gnt", {31'd0, d_gnt}, 0);
      chk("rst_f_rvalid", {31'd0, f_rvalid}, 0);
      chk("rst_d_rvalid", {31'd0, d_rvalid}, 0);
      chk("rst_f_err", {31'd0, f_err}, 0);
      chk("rst_d_err", {31'd0, d_err}, 0);
      chk("rst_f_rdata", f_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_mem_address", 32'(mem_address), 0);
      fq.delete();
      dq.delete();
    end else begin
      if (fq.size() != 0) begin
        chk("f_rvalid", {31'd0, f_rvalid}, 1);
        chk("f_rdata", f_rdata, fq[0].data);
        chk("f_err", {31'd0, f_err}, {31'd0, fq[0].err});
        if (f_rready) void'(fq.pop_front());
      end else begin
        chk("f_rvalid_idle", {31'd0, f_rvalid}, 0);
      end
      if (dq.size() != 0) begin
        chk("d_rvalid", {31'd0, d_rvalid}, 1);
        chk("d_rdata", d_rdata, dq[0].data);
        chk("d_err", {31'd0, d_err}, {31'd0, dq[0].err});
        if (d_rready) void'(dq.pop_front());
      end else begin
        chk("d_rvalid_idle", {31'd0, d_rvalid}, 0);
      end
    end
  end

  // Reference model: a port may be granted when nothing is owed to it after
  // this cycle's hand-off; the response is owed from the next cycle on.
  always @(negedge clock) begin
    bit fe, de, dw, fw;
    logic [AW-1:0] exp_addr;
    #1;
    if (reset) begin
      last_f = 1'b1;
    end else begin
      fe = f_req && fq.size() == 0;
      de = d_req && dq.size() == 0;
      dw = de && (!fe || !RR || last_f);
      fw = fe && !dw;
      exp_addr = dw ? d_addr : (fw ? f_addr : '0);
      chk("f_gnt", {31'd0, f_gnt}, {31'd0, fw});
      chk("d_gnt", {31'd0, d_gnt}, {31'd0, dw});
      chk("mem_address", 32'(mem_address), 32'(exp_addr));
      if (dw) begin dq.push_back(rom_read(d_addr)); last_f = 1'b0; end
      if (fw) begin fq.push_back(rom_read(f_addr)); last_f = 1'b1; end
    end
  end

  task automatic cyc(input logic fr, input logic [AW-1:0] fa, input logic frr,
                     input logic dr, input logic [AW-1:0] da, input logic drr);
    @(posedge clock);
    #2;
    f_req = fr; f_addr = fa; f_rready = frr;
    d_req = dr; d_addr = da; d_rready = drr;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clock);
    #2;
    reset = 1'b1;
    repeat (n) @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    idle(1);
    // single fetch
    cyc(1'b1, 8'h04, 1'b1, 1'b0, 8'h00, 1'b1);
    idle(2);
    // both requesting every cycle
    repeat (5) cyc(1'b1, 8'h08, 1'b1, 1'b1, 8'h0C, 1'b1);
    cyc(1'b1, 8'h08, 1'b1, 1'b0, 8'h00, 1'b1);
    idle(2);
    // D parked for 3 cycles, F served meanwhile, then drain + regrant of D
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 1'b0);
    repeat (3) cyc(1'b1, 8'h20, 1'b1, 1'b1, 8'h10, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h14, 1'b1);
    idle(2);
    // misaligned fetch
    cyc(1'b1, 8'h06, 1'b1, 1'b0, 8'h00, 1'b1);
    idle(2);
    // reset the cycle after a grant
    cyc(1'b1, 8'h04, 1'b1, 1'b0, 8'h00, 1'b1);
    idle(0);
    pulse_reset(2);
    idle(3);
    // randomized traffic with an occasional reset
    for (int i = 0; i < 500; i++) begin
      if (i == 250) pulse_reset(1);
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
